// File: rtl/twos_to_signmag_seq.sv
// ---------------------------------------------------------------------------
// twos_to_signmag_seq: chunked two's-complement to sign-magnitude converter
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module twos_to_signmag_seq #(
  parameter int WIDTH = 49,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_zero,
  output logic             out_minneg
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MINNEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   work_q, work_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sign_q, sign_d;
  logic            zero_q, zero_d;
  logic            minneg_q, minneg_d;

  logic [CHUNK-1:0] chunk_w;
  logic [CHUNK:0]   sum_w;
  logic [CHUNK-1:0] res_w;
  logic [PW-1:0]    rot_w;

  // The working word is padded to whole chunks and rotated right one chunk
  // per cycle, so the active chunk always sits at the bottom; after NCHUNK
  // rotations every chunk is back in its original position.
  assign chunk_w = work_q[CHUNK-1:0];
  assign sum_w   = {1'b0, ~chunk_w} + {{CHUNK{1'b0}}, carry_q};
  assign res_w   = sign_q ? sum_w[CHUNK-1:0] : chunk_w;

  generate
    if (NCHUNK == 1) begin : g_rot_single
      assign rot_w = res_w;
    end else begin : g_rot_multi
      assign rot_w = {res_w, work_q[PW-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    minneg_d = minneg_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_CONV;
          work_d   = PW'(in_data);
          sign_d   = in_data[WIDTH-1];
          idx_d    = '0;
          carry_d  = 1'b1;
          zero_d   = (in_data == '0);
          minneg_d = (in_data == MINNEG);
        end
      end
      S_CONV: begin
        work_d  = rot_w;
        carry_d = sign_q ? sum_w[CHUNK] : carry_q;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      minneg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      minneg_q <= minneg_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_sign   = sign_q;
  assign out_mag    = work_q[WIDTH-1:0];
  assign out_zero   = zero_q;
  assign out_minneg = minneg_q;

endmodule

`default_nettype wire

// File: tb/tb_twos_to_signmag_seq.sv
// ---------------------------------------------------------------------------
// tb_twos_to_signmag_seq: directed vectors plus randomized chunk-size sweep
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_twos_to_signmag_seq;

  localparam int W = 49;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         out_sign, out_zero, out_minneg;
  logic [W-1:0] in_data, out_mag;

  int checks = 0;
  int errors = 0;

  twos_to_signmag_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag),
    .out_zero(out_zero), .out_minneg(out_minneg)
  );

  // Sweep instances share inputs and run in lockstep, one per chunk size.
  logic         sv_iv, sv_ordy;
  logic [W-1:0] sv_id;
  logic         sv_ir [4];
  logic         sv_ov [4];
  logic         sv_os [4];
  logic         sv_oz [4];
  logic         sv_om [4];
  logic [W-1:0] sv_mag [4];
  int           nch_tab [4] = '{49, 7, 7, 1};
  int           ch_tab  [4] = '{1, 7, 8, 49};

  for (genvar k = 0; k < 4; k++) begin : g_sweep
    localparam int CH = (k == 0) ? 1 : (k == 1) ? 7 : (k == 2) ? 8 : 49;
    twos_to_signmag_seq #(.WIDTH(W), .CHUNK(CH)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(sv_iv), .in_ready(sv_ir[k]), .in_data(sv_id),
      .out_valid(sv_ov[k]), .out_ready(sv_ordy),
      .out_sign(sv_os[k]), .out_mag(sv_mag[k]),
      .out_zero(sv_oz[k]), .out_minneg(sv_om[k])
    );
  end

  // |x| from the signed value of the operand.
  function automatic logic [W-1:0] ref_mag(input logic [W-1:0] x);
    longint v;
    v = longint'(signed'(x));
    if (v < 0) v = -v;
    return W'(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] d, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin tick(); guard++; end
    chk("in_ready before issue", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
  endtask

  task automatic pop(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " out_valid after accept"}, out_valid, 0);
    chk({nm, " in_ready after accept"}, in_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    logic [W-1:0] m;
    logic         z;
    logic         mn;
  } vec_t;

  vec_t vt [7];

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, cnt, gap, bp, seen;
    int           slat [4];
    logic [W-1:0] x, xm;

    vt[0] = '{49'h1_FFFF_FFFF_FFFF, 1'b1, 49'h1,               1'b0, 1'b0};
    vt[1] = '{49'h0,                1'b0, 49'h0,               1'b1, 1'b0};
    vt[2] = '{49'h0_0000_0000_0123, 1'b0, 49'h123,             1'b0, 1'b0};
    vt[3] = '{49'h1_0000_0000_0000, 1'b1, 49'h1_0000_0000_0000, 1'b0, 1'b1};
    vt[4] = '{49'h1_FFFF_FFFF_FF00, 1'b1, 49'h100,             1'b0, 1'b0};
    vt[5] = '{49'h0_FFFF_FFFF_FFFF, 1'b0, 49'h0_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[6] = '{49'h1_FFFF_FFFF_FFFB, 1'b1, 49'h5,               1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    sv_iv = 1'b0; sv_ordy = 1'b0; sv_id = '0;
    repeat (3) tick();
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_mag", out_mag, 0);
    chk("reset out_sign", out_sign, 0);
    chk("reset out_zero", out_zero, 0);
    chk("reset out_minneg", out_minneg, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].d, lat);
      chk($sformatf("vec%0d latency", i), lat, 7);
      chk($sformatf("vec%0d sign", i), out_sign, vt[i].s);
      chk($sformatf("vec%0d mag", i), out_mag, vt[i].m);
      chk($sformatf("vec%0d zero", i), out_zero, vt[i].z);
      chk($sformatf("vec%0d minneg", i), out_minneg, vt[i].mn);
      pop($sformatf("vec%0d", i));
    end

    // Back-pressure: result must hold while new input activity is ignored.
    x = 49'h1_2345_6789_ABCD;
    run_op(x, lat);
    chk("bp latency", lat, 7);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = W'({$urandom, $urandom});
      tick();
      if (!out_valid || in_ready || out_mag !== ref_mag(x) || !out_sign) cnt++;
    end
    chk("bp hold violations", cnt, 0);
    chk("bp mag", out_mag, ref_mag(x));
    in_valid = 1'b0;
    pop("bp");

    // Reset while converting chunk 3 discards the operand.
    in_valid = 1'b1; in_data = 49'h0_0000_0000_0077;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (out_valid) cnt++; end
    chk("midrst spurious results", cnt, 0);
    run_op(49'h1_FFFF_FFFF_FFFB, lat);
    chk("midrst -5 latency", lat, 7);
    chk("midrst -5 mag", out_mag, 5);
    chk("midrst -5 sign", out_sign, 1);
    pop("midrst");

    // in_valid held high with out_ready high: one result every 9 cycles.
    in_valid = 1'b1; in_data = 49'h1_FFFF_FFFF_FF00; out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (out_valid) begin
        cnt++;
        chk("stream mag", out_mag, 49'h100);
      end
    end
    chk("stream result count", cnt, 3);
    in_valid = 1'b0;
    repeat (12) tick();
    out_ready = 1'b0;

    // Random sweep across chunk sizes against |x|.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0:       x = '0;
        1:       x = {1'b1, {(W-1){1'b0}}};
        2:       x = '1;
        3:       x = {1'b0, {(W-1){1'b1}}};
        default: x = {17'($urandom), 32'($urandom)};
      endcase
      xm  = ref_mag(x);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      for (int k = 0; k < 4; k++)
        chk($sformatf("c%0d in_ready", ch_tab[k]), sv_ir[k], 1);
      sv_iv = 1'b1; sv_id = x;
      tick();
      sv_iv = 1'b0; sv_id = W'({$urandom, $urandom});
      for (int k = 0; k < 4; k++) slat[k] = -1;
      seen = 0;
      for (int c = 1; c <= 300 && seen < 4; c++) begin
        tick();
        for (int k = 0; k < 4; k++)
          if (slat[k] < 0 && sv_ov[k]) begin slat[k] = c; seen++; end
      end
      bp = $urandom_range(0, 3);
      repeat (bp) tick();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("c%0d latency x=%h", ch_tab[k], x), slat[k], nch_tab[k]);
        chk($sformatf("c%0d mag x=%h", ch_tab[k], x), sv_mag[k], xm);
        chk($sformatf("c%0d sign x=%h", ch_tab[k], x), sv_os[k], x[W-1]);
        chk($sformatf("c%0d zero x=%h", ch_tab[k], x), sv_oz[k], x == '0);
        chk($sformatf("c%0d minneg x=%h", ch_tab[k], x), sv_om[k], x == {1'b1, {(W-1){1'b0}}});
      end
      sv_ordy = 1'b1;
      tick();
      sv_ordy = 1'b0;
      for (int k = 0; k < 4; k++)
        chk($sformatf("c%0d out_valid drop", ch_tab[k]), sv_ov[k], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/twos_to_signmag_seq.md
# twos_to_signmag_seq

Multi-cycle converter from two's-complement to sign-magnitude form. It is the inverse of the datapath negation units. A signed WIDTH-bit operand is taken in through a valid/ready handshake. The magnitude is produced CHUNK bits per cycle using a rippled increment carry, then held with its sign and status flags until the consumer accepts it. It sits between the signed mantissa/exponent arithmetic of the Nroot datapath and the normalisation/packing stage, which expects an unsigned magnitude plus a separate sign bit.

## Interface
- WIDTH, 49: operand width in bits (≥2).
- CHUNK, 8: bits converted per cycle (1..WIDTH). NCHUNK = ceil(WIDTH/CHUNK).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- out_sign  output  1  sign bit, equal to in_data[WIDTH-1].
- out_mag  output  WIDTH  unsigned magnitude |in_data|.
- out_zero  output  1  operand was 0.
- out_minneg  output  1  operand was -2^(WIDTH-1), so out_mag = 2^(WIDTH-1).

## Operation
- States:
  - IDLE: in_ready=1.
  - CONV: chunked conversion.
  - DONE: out_valid=1.
- IDLE→CONV on in_valid && in_ready.
  - Capture in_data into the working register.
  - Set sign = in_data[WIDTH-1], idx = 0, carry = 1.
- CONV, each cycle, on chunk idx (bits idx*CHUNK .. min((idx+1)*CHUNK, WIDTH)-1):
  - sign=0: chunk copied unchanged.
  - sign=1: {c, r} = ~chunk + carry; chunk ← r; carry ← c. The width of r equals the chunk width; the final chunk may be narrower.
  - idx increments. When idx = NCHUNK-1 is processed, go to DONE.
- out_zero and out_minneg are computed from the captured operand at the IDLE→CONV edge. They are registered and stable through DONE.
- DONE→IDLE on out_valid && out_ready. The outputs drop on that edge.
- in_data and in_valid are ignored outside IDLE. The operand is captured once and later changes have no effect.
- Magnitude arithmetic is modulo 2^WIDTH, unsigned. For -2^(WIDTH-1) the result is 1 followed by WIDTH-1 zeros, which is not an error.
- out_mag, out_sign, out_zero and out_minneg are valid only while out_valid=1. While out_valid=0 they show the working register, and there is no requirement on their value.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_sign=0, out_mag=0, out_zero=0, out_minneg=0.
  - idx=0, carry=0.
- rst overrides everything. Reset asserted in CONV or DONE returns the block to IDLE on that edge and drops the result with no output. in_ready=1 the cycle after.
- Latency: with the operand accepted at edge T, out_valid=1 from edge T+NCHUNK. For the defaults this is T+7.
- out_valid stays high and outputs stay stable until accepted. Back-pressure of any length is allowed.
- in_ready=0 in CONV and DONE. The next operand can be accepted no earlier than the cycle after the DONE→IDLE edge.
- Peak throughput is one operand per NCHUNK+2 cycles. No combinational path from in_valid to in_ready or from out_ready to out_valid.
- in_valid held high across a result: exactly one capture per IDLE visit.

## Test plan
1. Reset, then in_data=49'h1_FFFF_FFFF_FFFF (-1). Required: out_valid at acceptance+7, out_sign=1, out_mag=1, out_zero=0, out_minneg=0.
2. in_data=0. Required: out_sign=0, out_mag=0, out_zero=1. Then in_data=49'h0_0000_0000_0123. Required: out_mag=49'h123, out_sign=0.
3. in_data=49'h1_0000_0000_0000 (-2^48). Required: out_sign=1, out_mag=49'h1_0000_0000_0000, out_minneg=1. Then in_data=49'h1_FFFF_FFFF_FF00 (-256). Required: out_mag=49'h100, which checks carry ripple across chunks 0→1.
4. Back-pressure: hold out_ready=0 for 20 cycles after out_valid. Required: outputs stable, in_ready=0 throughout, and in_data changes ignored. On out_ready=1, out_valid falls at the next edge and in_ready=1.
5. Assert rst for one cycle at CONV idx=3. Required: next cycle IDLE, out_valid=0, in_ready=1, no spurious result. A fresh operand of -5 then yields out_mag=5.
6. Parameter sweep CHUNK∈{1,7,8,49}, WIDTH=49, with 1000 random operands against the reference |x|. Required: latency = NCHUNK (49,7,7,1 cycles) and every magnitude correct.
